// File: rtl/cal_pkg.sv
// cal_pkg: shared types and helpers for the calculator divider.
//   cal_div_state_t : divider FSM states
//   CAL_W           : default operand width
//   clog2()         : bit width needed to count 0..n-1, never less than 1
package cal_pkg;

    localparam int CAL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cal_div_state_t;

    function automatic int clog2(input int n);
        int bits;
        int v;
        bits = 0;
        v    = n - 1;
        while (v > 0) begin
            bits = bits + 1;
            v    = v >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/cal_div_step.sv
// cal_div_step: one combinational restoring-division iteration.
// Ports:
//   pr      in  W   partial remainder before this step (always < b)
//   msb     in  1   next dividend bit shifted into the remainder
//   b       in  W   divisor
//   pr_next out W   partial remainder after the trial subtract
//   q_bit   out 1   quotient bit produced by this step
module cal_div_step
    import cal_pkg::*;
#(
    parameter int W = CAL_W
) (
    input  logic [W-1:0] pr,
    input  logic         msb,
    input  logic [W-1:0] b,
    output logic [W-1:0] pr_next,
    output logic         q_bit
);

    // The shifted remainder needs W+1 bits so the compare never wraps.
    logic [W:0]   trial;
    logic [W-1:0] diff;

    always_comb begin
        trial = {pr, msb};
        q_bit = (trial >= {1'b0, b});
        // When the subtract is taken the result is below b, so the low
        // W bits of the difference are exact.
        diff    = trial[W-1:0] - b;
        pr_next = q_bit ? diff : trial[W-1:0];
    end

endmodule

// File: rtl/cal_div.sv
// cal_div: sequential unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk   in  1  clock, rising edge
//   rst   in  1  asynchronous active-high reset
//   start in  1  request, sampled in IDLE or DONE
//   a     in  W  dividend
//   b     in  W  divisor
//   q     out W  quotient (registered, holds until next completion)
//   r     out W  remainder (registered, holds until next completion)
//   busy  out 1  division in progress
//   done  out 1  one-cycle completion pulse
//   dz    out 1  divide-by-zero flag for the current result
module cal_div
    import cal_pkg::*;
#(
    parameter int W = CAL_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic         busy,
    output logic         done,
    output logic         dz
);

    localparam int CW = clog2(W);

    cal_div_state_t state, state_nx;

    logic [CW-1:0] cnt;
    logic [W-1:0]  dvd;
    logic [W-1:0]  quo;
    logic [W-1:0]  pr;
    logic [W-1:0]  div_b;
    logic [W-1:0]  pr_nx;
    logic          q_bit;
    logic          accept;

    cal_div_step #(.W(W)) u_step (
        .pr      (pr),
        .msb     (dvd[W-1]),
        .b       (div_b),
        .pr_next (pr_nx),
        .q_bit   (q_bit)
    );

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign busy   = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = (b == '0) ? DONE : RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            dvd   <= '0;
            quo   <= '0;
            pr    <= '0;
            div_b <= '0;
            q     <= '0;
            r     <= '0;
            dz    <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                div_b <= b;
                if (b == '0) begin
                    // Divide-by-zero completes on the accepting edge.
                    q    <= '1;
                    r    <= a;
                    dz   <= 1'b1;
                    done <= 1'b1;
                end else begin
                    pr  <= '0;
                    dvd <= a;
                    quo <= '0;
                    cnt <= CW'(W - 1);
                    dz  <= 1'b0;
                end
            end else if (state == RUN) begin
                pr  <= pr_nx;
                dvd <= {dvd[W-2:0], 1'b0};
                quo <= {quo[W-2:0], q_bit};
                cnt <= cnt - CW'(1);
                if (cnt == '0) begin
                    q    <= {quo[W-2:0], q_bit};
                    r    <= pr_nx;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cal_div.sv
// tb_cal_div: scoreboard bench for cal_div (W=4 directed plus W=8 invariant).
module tb_cal_div;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start;
    logic [3:0] a, b, q, r;
    logic       busy, done, dz;

    logic       start8;
    logic [7:0] a8, b8, q8, r8;
    logic       busy8, done8, dz8;

    always #5 clk = ~clk;

    cal_div #(.W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .q(q), .r(r), .busy(busy), .done(done), .dz(dz)
    );

    cal_div #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .q(q8), .r(r8), .busy(busy8), .done(done8), .dz(dz8)
    );

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
        int         due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expect_res(input logic [3:0] qe, input logic [3:0] re,
                              input logic dze, input int due);
        exp_t e;
        e.q   = qe;
        e.r   = re;
        e.dz  = dze;
        e.due = due;
        sb.push_back(e);
    endtask

    // Drives one request; returns at the falling edge after the accepting edge.
    task automatic issue(input logic [3:0] av, input logic [3:0] bv,
                         input logic [3:0] qe, input logic [3:0] re, input logic dze);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        expect_res(qe, re, dze, (bv == 4'd0) ? cyc : cyc + 4);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: %0d results pending, required 0", sb.size());
            sb.delete();
        end
        #1;
    endtask

    // Monitor: compare every done pulse against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            check("done_busy_excl", int'(done && busy), 0);
            if (done) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 with q=%0d r=%0d, required no pulse", q, r);
                end else begin
                    mon_e = sb.pop_front();
                    check("q", int'(q), int'(mon_e.q));
                    check("r", int'(r), int'(mon_e.r));
                    check("dz", int'(dz), int'(mon_e.dz));
                    check("latency", cyc, mon_e.due);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        start  = 1'b0;
        a      = '0;
        b      = '0;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        rst    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_q", int'(q), 0);
        check("rst_r", int'(r), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_dz", int'(dz), 0);
        rst = 1'b0;

        // 13/3 with busy window and single-cycle done
        issue(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
        check("busy_e0", int'(busy), 1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check("busy_run", int'(busy), 1);
        end
        @(negedge clk);
        check("busy_end", int'(busy), 0);
        check("done_pulse", int'(done), 1);
        @(negedge clk);
        check("done_fall", int'(done), 0);
        wait_done();

        // boundary values
        issue(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);  wait_done();
        issue(4'd5, 4'd7, 4'd0, 4'd5, 1'b0);    wait_done();
        issue(4'd0, 4'd9, 4'd0, 4'd0, 1'b0);    wait_done();
        issue(4'd15, 4'd15, 4'd1, 4'd0, 1'b0);  wait_done();
        repeat (3) @(negedge clk);
        check("hold_q", int'(q), 1);
        check("hold_r", int'(r), 0);

        // divide by zero, then a normal division clears dz
        issue(4'd9, 4'd0, 4'd15, 4'd9, 1'b1);
        check("dz_busy", int'(busy), 0);
        wait_done();
        issue(4'd8, 4'd2, 4'd4, 4'd0, 1'b0);
        wait_done();

        // start held through RUN is ignored, then accepted in DONE
        @(negedge clk);
        a     = 4'd13;
        b     = 4'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        expect_res(4'd4, 4'd1, 1'b0, cyc + 4);
        @(negedge clk);
        a = 4'd7;
        b = 4'd2;
        repeat (5) @(posedge clk);
        #1;
        expect_res(4'd3, 4'd1, 1'b0, cyc + 4);
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // asynchronous reset mid-run aborts with no done afterwards
        @(negedge clk);
        a     = 4'd13;
        b     = 4'd3;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_q", int'(q), 0);
        check("abort_r", int'(r), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_dz", int'(dz), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        issue(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
        wait_done();

        // exhaustive W=4 sweep against a reference model
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                if (bi == 0) begin
                    issue(4'(ai), 4'(bi), 4'd15, 4'(ai), 1'b1);
                end else begin
                    issue(4'(ai), 4'(bi), 4'(ai / bi), 4'(ai % bi), 1'b0);
                end
                wait_done();
            end
        end

        // W=8 random pairs checked against the division invariant
        for (int i = 0; i < 1000; i++) begin
            int av, bv, qi, ri, k, ok;
            av = int'($urandom_range(0, 255));
            bv = (i % 97 == 0) ? 0 : int'($urandom_range(0, 255));
            @(negedge clk);
            a8     = 8'(av);
            b8     = 8'(bv);
            start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            k = 0;
            while (!done8 && k < 20) begin
                @(negedge clk);
                k++;
            end
            if (!done8) begin
                n_cmp++;
                n_bad++;
                $display("FAIL w8_timeout: a=%0d b=%0d got no done, required done", av, bv);
            end else begin
                qi = int'(q8);
                ri = int'(r8);
                if (bv == 0) begin
                    ok = (dz8 && qi == 255 && ri == av) ? 1 : 0;
                end else begin
                    ok = (!dz8 && av == qi * bv + ri && ri < bv) ? 1 : 0;
                end
                if (ok == 0) begin
                    $display("FAIL w8_detail: a=%0d b=%0d got q=%0d r=%0d dz=%0d", av, bv, qi, ri, dz8);
                end
                check("w8_invariant", ok, 1);
            end
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
